// File: rtl/minterm_scanner.sv
// minterm_scanner: walks all 2^N_VARS input vectors through an external
// combinational function block, holds each vector SETTLE+1 cycles, samples
// the block's output on the last edge of the hold, builds the truth table
// and compares it against an expected minterm mask captured at start.
//
// Optional build macro: SCAN_ABORT_EN
//   defined   -> scan stops at the first sample that disagrees with the mask
//   undefined -> full scan always completes, comparison done at the end
//
// Handshake: start is a level request sampled only in IDLE; while busy or in
// DONE it is ignored (never queued). done is a one-cycle pulse; table_out,
// match and err_idx hold their values from done until the next accepted start.
module minterm_scanner #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(1<<N_VARS)-1:0]   exp_mask,
  input  logic                     f_in,
  output logic [N_VARS-1:0]        vec_out,
  output logic                     busy,
  output logic                     done,
  output logic [(1<<N_VARS)-1:0]   table_out,
  output logic                     match,
  output logic [N_VARS-1:0]        err_idx,
  output logic [1:0]               state_dbg
);

  localparam int TW = 1 << N_VARS;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE);
  localparam logic [N_VARS-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [N_VARS-1:0]  vec_q, vec_nx;
  logic [CW-1:0]      cnt_q, cnt_nx;
  logic [TW-1:0]      tbl_q, tbl_nx;
  logic [TW-1:0]      mask_q, mask_nx;
  logic               match_q, match_nx;
  logic [N_VARS-1:0]  err_q, err_nx;

  // table including the bit being sampled this cycle, and its comparison
  logic [TW-1:0]      tbl_smp;
  logic [TW-1:0]      diff;
  logic [N_VARS-1:0]  low_idx;
  logic               finish;

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      tbl_q   <= '0;
      mask_q  <= '0;
      match_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state   <= state_nx;
      vec_q   <= vec_nx;
      cnt_q   <= cnt_nx;
      tbl_q   <= tbl_nx;
      mask_q  <= mask_nx;
      match_q <= match_nx;
      err_q   <= err_nx;
    end
  end

  // Sampled table view, mismatch vector and its lowest set bit.
  always_comb begin
    tbl_smp         = tbl_q;
    tbl_smp[vec_q]  = f_in;
    diff            = tbl_smp ^ mask_q;
    low_idx         = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (diff[i]) low_idx = N_VARS'(i);
    end
`ifdef SCAN_ABORT_EN
    // Early exit: all lower samples already agreed, so low_idx == vec_q here.
    finish = (vec_q == VEC_LAST) || (f_in != mask_q[vec_q]);
`else
    finish = (vec_q == VEC_LAST);
`endif
  end

  // Next-state and register updates for the scan sequencer.
  always_comb begin
    state_nx = state;
    vec_nx   = vec_q;
    cnt_nx   = cnt_q;
    tbl_nx   = tbl_q;
    mask_nx  = mask_q;
    match_nx = match_q;
    err_nx   = err_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_HOLD;
          vec_nx   = '0;
          cnt_nx   = '0;
          tbl_nx   = '0;
          match_nx = 1'b0;
          err_nx   = '0;
          mask_nx  = exp_mask;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_nx = '0;
          tbl_nx = tbl_smp;
          if (finish) begin
            state_nx = S_DONE;
            vec_nx   = '0;
            match_nx = (diff == '0);
            err_nx   = low_idx;
          end else begin
            vec_nx = vec_q + 1'b1;
          end
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign vec_out   = vec_q;
  assign busy      = (state == S_HOLD);
  assign done      = (state == S_DONE);
  assign table_out = tbl_q;
  assign match     = match_q;
  assign err_idx   = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_minterm_scanner.sv
// Bench for minterm_scanner: two instances (SETTLE=1 and SETTLE=3) driven by
// directed and random scans, checked against a truth-table model.
module tb_minterm_scanner;

  localparam int NV = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // per-instance signals: index 0 -> SETTLE=1, index 1 -> SETTLE=3
  logic        start    [2];
  logic [15:0] mask_in  [2];
  logic        f_in     [2];
  logic [3:0]  vec_v    [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic [15:0] table_v  [2];
  logic        match_v  [2];
  logic [3:0]  err_v    [2];
  logic [1:0]  st_v     [2];

  // function block models feeding f_in from the current vector
  logic [15:0] fn_q  [2];
  logic        stuck [2];
  assign f_in[0] = stuck[0] ? 1'b0 : fn_q[0][vec_v[0]];
  assign f_in[1] = stuck[1] ? 1'b0 : fn_q[1][vec_v[1]];

  minterm_scanner #(.N_VARS(NV), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .exp_mask(mask_in[0]),
    .f_in(f_in[0]), .vec_out(vec_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .table_out(table_v[0]), .match(match_v[0]), .err_idx(err_v[0]),
    .state_dbg(st_v[0])
  );

  minterm_scanner #(.N_VARS(NV), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .exp_mask(mask_in[1]),
    .f_in(f_in[1]), .vec_out(vec_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .table_out(table_v[1]), .match(match_v[1]), .err_idx(err_v[1]),
    .state_dbg(st_v[1])
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // lowest index where two truth tables disagree, -1 if identical
  function automatic int first_diff(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      if (a[i] != b[i]) return i;
    end
    return -1;
  endfunction

  // driver: one scan on instance u, checked end to end against the model
  task automatic run_scan(input int u, input logic [15:0] fn, input logic [15:0] mask,
                          input bit stk, input bit repulse);
    int s, d, t_exp, t_seen, vec_bad, busy_bad;
    logic [15:0] fe, et;
    logic [16:0] keep;
    bit abort_mode;
    s  = (u == 0) ? 1 : 3;
    fe = stk ? 16'h0 : fn;
    d  = first_diff(fe, mask);
`ifdef SCAN_ABORT_EN
    abort_mode = 1'b1;
`else
    abort_mode = 1'b0;
`endif
    if (abort_mode && d >= 0) begin
      t_exp = (d + 1) * (s + 1);
      keep  = (17'd1 << (d + 1)) - 17'd1;
      et    = fe & keep[15:0];
    end else begin
      t_exp = 16 * (s + 1);
      et    = fe;
    end
    // expected results queued: table, match, err_idx
    exp_q.push_back({16'h0, et});
    exp_q.push_back((d < 0) ? 32'd1 : 32'd0);
    exp_q.push_back((d < 0) ? 32'd0 : 32'(d));

    @(negedge clk);
    fn_q[u]    = fn;
    stuck[u]   = stk;
    mask_in[u] = mask;
    start[u]   = 1'b1;
    @(posedge clk);
    #1;
    start[u]   = 1'b0;
    mask_in[u] = 16'($urandom);  // must not affect the running scan
    vec_bad  = (vec_v[u] !== 4'd0) ? 1 : 0;
    busy_bad = (busy_v[u] !== 1'b1) ? 1 : 0;
    t_seen = -1;
    for (int j = 1; j <= t_exp + 4 && t_seen < 0; j++) begin
      @(posedge clk);
      #1;
      if (done_v[u] === 1'b1) begin
        t_seen = j;
      end else begin
        if (vec_v[u] !== 4'(j / (s + 1))) vec_bad++;
        if (busy_v[u] !== 1'b1) busy_bad++;
      end
      start[u] = (repulse && (j == 4 || j == 19)) ? 1'b1 : 1'b0;
    end
    start[u] = 1'b0;
    check_val("done_edge", 32'(t_seen), 32'(t_exp));
    check_val("table", {16'h0, table_v[u]}, exp_q.pop_front());
    check_val("match", {31'h0, match_v[u]}, exp_q.pop_front());
    check_val("err_idx", {28'h0, err_v[u]}, exp_q.pop_front());
    check_val("busy_at_done", {31'h0, busy_v[u]}, 32'd0);
    check_val("vec_at_done", {28'h0, vec_v[u]}, 32'd0);
    check_val("vec_seq_errs", 32'(vec_bad), 32'd0);
    check_val("busy_errs", 32'(busy_bad), 32'd0);
    @(posedge clk);
    #1;
    check_val("done_pulse", {31'h0, done_v[u]}, 32'd0);
    check_val("idle_busy", {31'h0, busy_v[u]}, 32'd0);
    check_val("hold_match", {31'h0, match_v[u]}, (d < 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_state(input int u, input string tag);
    check_val({tag, "_outs"},
              {7'h0, vec_v[u], busy_v[u], done_v[u], match_v[u], err_v[u], table_v[u]},
              32'd0);
  endtask

  initial begin
    logic [15:0] fn, mk;
    int u, mode;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; mask_in[i] = 16'h0; fn_q[i] = 16'h0; stuck[i] = 1'b0;
    end
    #2;
    check_reset_state(0, "reset0");
    check_reset_state(1, "reset1");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_scan(0, 16'h48C6, 16'h48C6, 1'b0, 1'b0);   // correct function
    run_scan(0, 16'h48C6, 16'h48C6, 1'b1, 1'b0);   // output stuck at 0
    run_scan(0, 16'h08C6, 16'h48C6, 1'b0, 1'b0);   // F(14) fault
    run_scan(0, 16'h48C6, 16'h48C6, 1'b0, 1'b1);   // start re-pulsed mid-scan
    run_scan(1, 16'h48C6, 16'h48C6, 1'b0, 1'b0);   // SETTLE=3
    run_scan(0, 16'h48C7, 16'h48C6, 1'b0, 1'b0);   // mismatch at index 0
    run_scan(0, 16'hC8C6, 16'h48C6, 1'b0, 1'b0);   // mismatch at index 15

    // reset mid-scan
    @(negedge clk);
    fn_q[0] = 16'h48C6; stuck[0] = 1'b0; mask_in[0] = 16'h48C6; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_state(0, "midscan_reset");
    check_val("midscan_state", {30'h0, st_v[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(0, 16'h48C6, 16'h48C6, 1'b0, 1'b0);

    // random scans
    for (int n = 0; n < 30; n++) begin
      u    = $urandom_range(0, 1);
      fn   = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0)      mk = fn;
      else if (mode == 1) mk = fn ^ (16'h1 << $urandom_range(0, 15));
      else                mk = 16'($urandom);
      run_scan(u, fn, mk, ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/minterm_scanner.md
Name: minterm_scanner

Overview:
- Sequencer that exhaustively drives all 2^N_VARS input combinations into an external combinational function block, such as the mux-based boolean evaluator.
- Samples the block's single-bit output for each combination, assembles the full truth table and compares it against an expected minterm mask.
- Sits beside the function block as its test/configuration controller; a host pulses start and reads table, match flag and first failing index.

Parameters:
- N_VARS, 4, number of function inputs; vec_out width; table width = 2^N_VARS
- SETTLE, 1, extra hold cycles per vector before sampling (≥0); vector held SETTLE+1 cycles total

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  scan request, sampled in IDLE only
- exp_mask  input  2^N_VARS  expected truth table, bit i = F(i); captured on start acceptance
- f_in  input  1  output of the function block under control
- vec_out  output  N_VARS  drive to function inputs; MSB = a, LSB = d for N_VARS=4
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse at scan end
- table_out  output  2^N_VARS  captured truth table, bit i = f_in sampled with vec_out=i
- match  output  1  table_out == captured mask; valid from done until next start acceptance
- err_idx  output  N_VARS  lowest index where table_out and mask differ; 0 when match=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; vec_out=0, busy=0, done=0, table_out=0, match=0, err_idx=0; hold counter and internal mask copy cleared. Reset mid-scan aborts immediately; no partial done.
- States: IDLE, HOLD, DONE.
- IDLE: start=1 at edge k → HOLD; busy=1, vec_out=0, hold count=0, table_out=0, match=0, err_idx=0, mask copy=exp_mask.
- HOLD: hold count increments each edge. On the edge where count==SETTLE:
  - f_in written into table_out[vec_out].
  - Count reset to 0.
  - If vec_out≠2^N_VARS−1, vec_out increments; otherwise → DONE.
- Timing:
  - Each vector is held exactly SETTLE+1 cycles.
  - f_in is sampled on the last edge of that hold.
- DONE (single cycle):
  - done=1 and busy=0, both set on the final sample edge k+2^N_VARS·(SETTLE+1).
  - match and err_idx are computed from the final table (err_idx = lowest set bit of table_out XOR mask).
  - vec_out returns to 0; next edge → IDLE with done=0.
- start while busy or in DONE: ignored, not queued. start held high continuously re-triggers a new scan from IDLE each time.
- exp_mask changes after acceptance do not affect the current scan.
- vec_out wraps only via DONE; no modular overflow.
- Defaults N_VARS=4, SETTLE=1: 32 cycles per scan.

Optional Feature:
- Macro SCAN_ABORT_EN.
- Defined: each sample is compared against mask bit i as captured. On the first mismatch:
  - Go directly to DONE with match=0 and err_idx=i.
  - Unscanned table bits remain 0.
  - done asserts on that sample edge.
- Undefined: full scan always completes; comparison only at end, as above.

Test Plan:
- Correct F=Σ(1,2,6,7,11,14), exp_mask=16'h48C6, SETTLE=1, pulse start → busy 32 cycles, done pulse on edge 32, table_out=16'h48C6, match=1, err_idx=0.
- f_in stuck at 0, exp_mask=16'h48C6 → table_out=16'h0000, match=0, err_idx=1; with SCAN_ABORT_EN, done on edge 4 (2 vectors × 2 cycles), err_idx=1.
- Single fault F(14)=0 (function 16'h08C6) → table_out=16'h08C6, match=0, err_idx=14.
- start re-pulsed at cycles 5 and 20 of a scan → ignored; exactly one done at cycle 32; vec_out sequence 0..15, each held 2 cycles.
- rst_n low at cycle 10 of a scan → all outputs 0 asynchronously; release, pulse start → fresh full scan with table_out=16'h48C6 and match=1.
- SETTLE=3, correct function → each vec_out value held 4 cycles, done on edge 64, match=1.
